// File: rtl/pipe_skid_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_skid_buffer_pkg
// Brief   : State encoding and debug helper shared by the skid buffer files.
// Revision: 1.0
// ============================================================================
package pipe_skid_buffer_pkg;

  localparam int unsigned STATE_WIDTH = 2;

  localparam logic [1:0] STATE_EMPTY = 2'b00;
  localparam logic [1:0] STATE_BUSY  = 2'b01;
  localparam logic [1:0] STATE_FULL  = 2'b10;

  function automatic string state_name(input logic [1:0] state);
    case (state)
      STATE_EMPTY: return "EMPTY";
      STATE_BUSY:  return "BUSY";
      STATE_FULL:  return "FULL";
      default:     return "ILLEGAL";
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_skid_buffer_register_with_clear.sv
`default_nettype none
// ============================================================================
// Module  : register_with_clear
// Brief   : Enabled register with synchronous clear to a parameterized value.
// Revision: 1.0
// ============================================================================
module register_with_clear #(
  parameter int unsigned              WORD_WIDTH  = 1,
  parameter logic [WORD_WIDTH-1:0]    RESET_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [WORD_WIDTH-1:0] d,
  output logic [WORD_WIDTH-1:0] q
);

  // Declaration initializer gives the same power-up value as reset.
  logic [WORD_WIDTH-1:0] value_q = RESET_VALUE;

  always_ff @(posedge clock) begin
    if (clear) begin
      value_q <= RESET_VALUE;
    end else if (enable) begin
      value_q <= d;
    end
  end

  assign q = value_q;

endmodule
`default_nettype wire

// File: rtl/pipe_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module  : pipe_skid_buffer
// Brief   : Two-entry registered ready/valid stage; every output is a flop.
// Revision: 1.0
// ============================================================================
module pipe_skid_buffer
  import pipe_skid_buffer_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 0
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  input_valid,
  output logic                  input_ready,
  input  logic [WORD_WIDTH-1:0] input_data,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [WORD_WIDTH-1:0] output_data
);

  logic [STATE_WIDTH-1:0] state_d, state_q;
  logic [WORD_WIDTH-1:0]  output_data_d, output_data_q;
  logic [WORD_WIDTH-1:0]  skid_data_d, skid_data_q;
  logic                   input_ready_d, input_ready_q;
  logic                   output_valid_d, output_valid_q;
  logic                   output_load, skid_load, output_from_skid;
  logic                   insert, remove;

  always_comb begin
    insert           = input_valid & input_ready_q;
    remove           = output_valid_q & output_ready;
    state_d          = state_q;
    output_load      = 1'b0;
    skid_load        = 1'b0;
    output_from_skid = 1'b0;

    case (state_q)
      STATE_EMPTY: begin
        if (insert) begin
          state_d     = STATE_BUSY;
          output_load = 1'b1;
        end
      end
      STATE_BUSY: begin
        if (insert && !remove) begin
          state_d   = STATE_FULL;
          skid_load = 1'b1;
        end else if (insert && remove) begin
          output_load = 1'b1;
        end else if (remove) begin
          state_d = STATE_EMPTY;
        end
      end
      STATE_FULL: begin
        if (remove) begin
          state_d          = STATE_BUSY;
          output_load      = 1'b1;
          output_from_skid = 1'b1;
        end
      end
      default: state_d = STATE_EMPTY;
    endcase

    output_data_d  = output_from_skid ? skid_data_q : input_data;
    skid_data_d    = input_data;
    // Handshake flags are decoded from the next state so they are flops, not logic.
    input_ready_d  = (state_d != STATE_FULL);
    output_valid_d = (state_d != STATE_EMPTY);
  end

  register_with_clear #(.WORD_WIDTH(STATE_WIDTH), .RESET_VALUE(STATE_EMPTY)) u_state_reg (
    .clock (clock), .clear (clear), .enable (1'b1), .d (state_d), .q (state_q)
  );

  register_with_clear #(.WORD_WIDTH(WORD_WIDTH), .RESET_VALUE('0)) u_output_data_reg (
    .clock (clock), .clear (clear), .enable (output_load), .d (output_data_d), .q (output_data_q)
  );

  register_with_clear #(.WORD_WIDTH(WORD_WIDTH), .RESET_VALUE('0)) u_skid_data_reg (
    .clock (clock), .clear (clear), .enable (skid_load), .d (skid_data_d), .q (skid_data_q)
  );

  register_with_clear #(.WORD_WIDTH(1), .RESET_VALUE(1'b1)) u_input_ready_reg (
    .clock (clock), .clear (clear), .enable (1'b1), .d (input_ready_d), .q (input_ready_q)
  );

  register_with_clear #(.WORD_WIDTH(1), .RESET_VALUE(1'b0)) u_output_valid_reg (
    .clock (clock), .clear (clear), .enable (1'b1), .d (output_valid_d), .q (output_valid_q)
  );

  assign input_ready  = input_ready_q;
  assign output_valid = output_valid_q;
  assign output_data  = output_data_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_skid_buffer
// Brief   : Directed and randomized self-checking bench for pipe_skid_buffer.
// Revision: 1.0
// ============================================================================
module tb_pipe_skid_buffer;

  localparam int unsigned WORD_WIDTH = 8;

  logic                  clock = 1'b0;
  logic                  clear;
  logic                  input_valid;
  logic                  input_ready;
  logic [WORD_WIDTH-1:0] input_data;
  logic                  output_valid;
  logic                  output_ready;
  logic [WORD_WIDTH-1:0] output_data;

  int checks = 0;
  int errors = 0;

  pipe_skid_buffer #(.WORD_WIDTH(WORD_WIDTH)) dut (
    .clock        (clock),
    .clear        (clear),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  logic [WORD_WIDTH-1:0] model_q[$];
  logic [WORD_WIDTH-1:0] next_data;
  logic [WORD_WIDTH-1:0] held_data;
  logic                  held;
  logic                  ins, rem;

  initial begin
    clear = 1'b1; input_valid = 1'b0; output_ready = 1'b0; input_data = '0;
    step();
    clear = 1'b0;
    check("reset_ready", 32'(input_ready), 32'd1);
    check("reset_valid", 32'(output_valid), 32'd0);
    check("reset_data", 32'(output_data), 32'h00);

    // Single word
    input_valid = 1'b1; input_data = 8'hA5; output_ready = 1'b1;
    step();
    input_valid = 1'b0;
    check("single_valid", 32'(output_valid), 32'd1);
    check("single_data", 32'(output_data), 32'hA5);
    step();
    check("single_drain", 32'(output_valid), 32'd0);

    // Streaming
    for (int i = 1; i <= 16; i++) begin
      input_valid = 1'b1; input_data = 8'(i);
      step();
      check("stream_valid", 32'(output_valid), 32'd1);
      check("stream_data", 32'(output_data), 32'(i));
      check("stream_ready", 32'(input_ready), 32'd1);
    end
    input_valid = 1'b0;
    step();
    check("stream_drain", 32'(output_valid), 32'd0);

    // Stall and skid
    input_valid = 1'b1; input_data = 8'h20; output_ready = 1'b1;
    step();
    check("stall_first", 32'(output_data), 32'h20);
    output_ready = 1'b0; input_data = 8'h21;
    step();
    check("stall_full_ready", 32'(input_ready), 32'd0);
    check("stall_full_data", 32'(output_data), 32'h20);
    input_data = 8'h22;
    step();
    check("stall_hold_ready", 32'(input_ready), 32'd0);
    check("stall_hold_data", 32'(output_data), 32'h20);
    check("stall_hold_valid", 32'(output_valid), 32'd1);
    output_ready = 1'b1;
    step();
    check("recover_data21", 32'(output_data), 32'h21);
    check("recover_ready", 32'(input_ready), 32'd1);
    step();
    check("recover_data22", 32'(output_data), 32'h22);
    input_valid = 1'b0;
    step();
    check("recover_drain", 32'(output_valid), 32'd0);

    // Clear while FULL discards both words
    output_ready = 1'b0; input_valid = 1'b1; input_data = 8'h33;
    step();
    input_data = 8'h34;
    step();
    check("full_before_clear", 32'(input_ready), 32'd0);
    clear = 1'b1; output_ready = 1'b1;
    step();
    clear = 1'b0; input_valid = 1'b0;
    check("clear_full_valid", 32'(output_valid), 32'd0);
    check("clear_full_ready", 32'(input_ready), 32'd1);
    check("clear_full_data", 32'(output_data), 32'h00);

    // Random traffic against a queue model
    next_data = 8'h00;
    held = 1'b0;
    held_data = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      check("rand_ready_occ", 32'(input_ready), 32'(model_q.size() < 2));
      check("rand_valid_occ", 32'(output_valid), 32'(model_q.size() != 0));
      if (held) begin
        check("rand_hold_valid", 32'(output_valid), 32'd1);
        check("rand_hold_data", 32'(output_data), 32'(held_data));
      end
      input_valid  = 1'($urandom_range(0, 1));
      output_ready = 1'($urandom_range(0, 1));
      input_data   = next_data;
      ins = input_valid & input_ready;
      rem = output_valid & output_ready;
      held = output_valid & ~output_ready;
      held_data = output_data;
      if (rem) begin
        if (model_q.size() == 0) begin
          check("rand_remove_empty", 32'd1, 32'd0);
        end else begin
          check("rand_order", 32'(output_data), 32'(model_q.pop_front()));
        end
      end
      if (ins) begin
        model_q.push_back(next_data);
        next_data = next_data + 8'd1;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
